// File: rtl/caliptra_prim_cdc_delay_pkg.sv
// rtl/caliptra_prim_cdc_delay_pkg.sv - shared types and constants for the CDC delay scheduler
package caliptra_prim_cdc_delay_pkg;

  typedef enum logic [1:0] {
    ModeOff    = 2'd0,
    ModeRandom = 2'd1,
    ModeAlways = 2'd2,
    ModeRsvd   = 2'd3
  } cdc_delay_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSeed = 2'd1,
    StRun  = 2'd2
  } sched_state_e;

  localparam logic [31:0] LfsrTaps       = 32'h8020_0003;
  localparam logic [31:0] DefaultSeedVal = 32'hACE1_2D5B;

  // Galois form: shift right, fold the taps in when the bit shifted out is set.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ ({32{s[0]}} & LfsrTaps);
  endfunction

endpackage

// File: rtl/caliptra_prim_cdc_delay_lfsr.sv
// rtl/caliptra_prim_cdc_delay_lfsr.sv - 32-bit Galois LFSR with load/enable
// A zero seed would lock the register, so it is replaced by DefaultSeed on load.
module caliptra_prim_cdc_delay_lfsr
  import caliptra_prim_cdc_delay_pkg::*;
#(
  parameter logic [31:0] DefaultSeed = DefaultSeedVal
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == 32'h0) ? DefaultSeed : seed_i;
    end else if (en_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DefaultSeed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/caliptra_prim_cdc_delay_sched.sv
// rtl/caliptra_prim_cdc_delay_sched.sv - per-bit hold/take select generator for CDC delay emulation
// sel_o bit = 1 makes the synchronizer keep its previous value for that bit this cycle.
module caliptra_prim_cdc_delay_sched
  import caliptra_prim_cdc_delay_pkg::*;
#(
  parameter int unsigned DataWidth   = 1,
  parameter int unsigned MaxConsec   = 1,
  parameter logic [31:0] DefaultSeed = DefaultSeedVal
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [1:0]           cfg_mode_i,
  input  logic [31:0]          cfg_seed_i,
  input  logic [DataWidth-1:0] src_data_i,
  input  logic [DataWidth-1:0] prev_data_i,
  output logic [DataWidth-1:0] sel_o,
  output logic                 active_o,
  output logic [15:0]          delay_cnt_o
);

  if (DataWidth < 1 || DataWidth > 32) begin : gen_dw_chk
    $error("DataWidth must be in 1..32");
  end
  if (MaxConsec < 1 || MaxConsec > 7) begin : gen_mc_chk
    $error("MaxConsec must be in 1..7");
  end

  localparam logic [2:0] MaxCnt = 3'(MaxConsec);

  sched_state_e              state_q, state_d;
  cdc_delay_mode_e           mode_q, mode_d, cfg_mode;
  logic [DataWidth-1:0]      sel_q, sel_d, chg, cand, sel_nxt;
  logic [DataWidth-1:0][2:0] cnt_q, cnt_d;
  logic [15:0]               delay_cnt_q, delay_cnt_d;
  logic                      ready_q, active_q;
  logic                      accept, cfg_run;
  logic [31:0]               lfsr;
  logic                      unused_lfsr;

  assign cfg_mode    = cdc_delay_mode_e'(cfg_mode_i);
  assign accept      = cfg_valid_i && ready_q;
  assign cfg_run     = (cfg_mode == ModeRandom) || (cfg_mode == ModeAlways);
  assign unused_lfsr = ^lfsr;

  caliptra_prim_cdc_delay_lfsr #(
    .DefaultSeed(DefaultSeed)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept && cfg_run),
    .seed_i (cfg_seed_i),
    .en_i   (state_q == StRun),
    .state_o(lfsr)
  );

  always_comb begin
    chg  = src_data_i ^ prev_data_i;
    cand = (mode_q == ModeRandom) ? (chg & lfsr[DataWidth-1:0]) : chg;
    for (int i = 0; i < DataWidth; i++) begin
      sel_nxt[i] = cand[i] && (cnt_q[i] < MaxCnt);
    end

    state_d = state_q;
    mode_d  = mode_q;
    sel_d   = '0;
    cnt_d   = '0;
    case (state_q)
      StSeed: state_d = StRun;
      StRun: begin
        sel_d = sel_nxt;
        for (int i = 0; i < DataWidth; i++) begin
          cnt_d[i] = sel_nxt[i] ? (cnt_q[i] + 3'd1) : 3'd0;
        end
      end
      default: ;
    endcase

    // A configuration accept overrides whatever the RUN mask would have been.
    if (accept) begin
      state_d = cfg_run ? StSeed : StIdle;
      mode_d  = cfg_run ? cfg_mode : ModeOff;
      sel_d   = '0;
      cnt_d   = '0;
    end

    delay_cnt_d = delay_cnt_q;
    if ((sel_d != '0) && (delay_cnt_q != 16'hFFFF)) begin
      delay_cnt_d = delay_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mode_q      <= ModeOff;
      sel_q       <= '0;
      cnt_q       <= '0;
      delay_cnt_q <= '0;
      ready_q     <= 1'b1;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      delay_cnt_q <= delay_cnt_d;
      ready_q     <= (state_d != StSeed);
      active_q    <= (state_d == StRun);
    end
  end

  assign sel_o       = sel_q;
  assign cfg_ready_o = ready_q;
  assign active_o    = active_q;
  assign delay_cnt_o = delay_cnt_q;

endmodule

// File: tb/tb_caliptra_prim_cdc_delay_sched.sv
// tb/tb_caliptra_prim_cdc_delay_sched.sv - directed self-checking bench for the CDC delay scheduler
module tb_caliptra_prim_cdc_delay_sched;

  localparam int DW = 4;
  localparam int MC = 2;
  localparam logic [31:0] DEF_SEED = 32'hACE1_2D5B;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_mode = 2'd0;
  logic [31:0]   cfg_seed = 32'h0;
  logic [DW-1:0] src_data = '0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] sel;
  logic          active;
  logic [15:0]   delay_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_lfsr;
  int          m_cnt[DW];
  logic [1:0]  m_mode;
  logic [15:0] exp_dcnt = 16'h0;

  caliptra_prim_cdc_delay_sched #(
    .DataWidth(DW),
    .MaxConsec(MC),
    .DefaultSeed(DEF_SEED)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_mode_i (cfg_mode),
    .cfg_seed_i (cfg_seed),
    .src_data_i (src_data),
    .prev_data_i(prev_data),
    .sel_o      (sel),
    .active_o   (active),
    .delay_cnt_o(delay_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init(input logic [1:0] mode, input logic [31:0] seed);
    m_lfsr = (seed == 32'h0) ? DEF_SEED : seed;
    m_mode = mode;
    for (int i = 0; i < DW; i++) m_cnt[i] = 0;
  endtask

  task automatic do_cfg(input logic [1:0] mode, input logic [31:0] seed);
    cfg_valid = 1'b1;
    cfg_mode  = mode;
    cfg_seed  = seed;
    step();
    cfg_valid = 1'b0;
    step();
    model_init(mode, seed);
  endtask

  task automatic drive_cycle(input logic [DW-1:0] src, input logic [DW-1:0] prev,
                             output logic [DW-1:0] exp_sel);
    logic [DW-1:0] chg, cand;
    src_data  = src;
    prev_data = prev;
    chg  = src ^ prev;
    cand = (m_mode == 2'd1) ? (chg & m_lfsr[DW-1:0]) : chg;
    for (int i = 0; i < DW; i++) begin
      exp_sel[i] = cand[i] && (m_cnt[i] < MC);
      m_cnt[i]   = exp_sel[i] ? m_cnt[i] + 1 : 0;
    end
    m_lfsr = ref_step(m_lfsr);
    if (exp_sel != '0 && exp_dcnt != 16'hFFFF) exp_dcnt = exp_dcnt + 16'd1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_vec++; if (sel !== 4'h0) begin n_err++; $display("FAIL reset_sel: got %h want 0", sel); end
    n_vec++; if (delay_cnt !== 16'h0) begin n_err++; $display("FAIL reset_dcnt: got %h want 0", delay_cnt); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
    exp_dcnt = 16'h0;
  endtask

  task automatic test_always();
    logic [DW-1:0] exp_tab[6] = '{4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0};
    logic [DW-1:0] e;
    do_cfg(2'd2, 32'h0);
    n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL always_active: got %b want 1", active); end
    for (int k = 0; k < 6; k++) begin
      drive_cycle(4'hF, 4'h0, e);
      n_vec++;
      if (sel !== exp_tab[k]) begin n_err++; $display("FAIL always_sel[%0d]: got %h want %h", k, sel, exp_tab[k]); end
    end
    n_vec++; if (delay_cnt !== 16'd4) begin n_err++; $display("FAIL always_dcnt: got %0d want 4", delay_cnt); end
  endtask

  task automatic test_random();
    logic [DW-1:0] e, s, p;
    do_cfg(2'd1, 32'h1);
    for (int k = 0; k < 100; k++) begin
      s = DW'($urandom);
      p = DW'($urandom);
      drive_cycle(s, p, e);
      n_vec++;
      if (sel !== e) begin n_err++; $display("FAIL random_sel[%0d]: got %h want %h", k, sel, e); end
      n_vec++;
      if ((sel & ~(s ^ p)) !== 4'h0) begin n_err++; $display("FAIL random_nochg[%0d]: got %h want 0", k, sel & ~(s ^ p)); end
    end
    n_vec++; if (delay_cnt !== exp_dcnt) begin n_err++; $display("FAIL random_dcnt: got %0d want %0d", delay_cnt, exp_dcnt); end
  endtask

  task automatic test_zero_seed();
    logic [DW-1:0] e;
    do_cfg(2'd1, 32'h0);
    drive_cycle(4'hF, 4'h0, e);
    n_vec++; if (sel !== 4'hB) begin n_err++; $display("FAIL zseed_first: got %h want b", sel); end
    for (int k = 0; k < 20; k++) begin
      drive_cycle(4'hF, 4'h0, e);
      n_vec++;
      if (sel !== e) begin n_err++; $display("FAIL zseed_sel[%0d]: got %h want %h", k, sel, e); end
    end
  endtask

  task automatic test_handshake();
    logic [DW-1:0] e;
    cfg_valid = 1'b1;
    cfg_mode  = 2'd2;
    cfg_seed  = 32'h5;
    step();
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL hs_seed_ready: got %b want 0", cfg_ready); end
    n_vec++; if (sel !== 4'h0) begin n_err++; $display("FAIL hs_seed_sel: got %h want 0", sel); end
    step();
    n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL hs_not_accepted: got active %b want 1", active); end
    step();
    n_vec++; if (cfg_ready !== 1'b0 || active !== 1'b0) begin
      n_err++; $display("FAIL hs_reaccept: got ready %b active %b want 0 0", cfg_ready, active);
    end
    cfg_valid = 1'b0;
    step();
    model_init(2'd2, 32'h5);
    drive_cycle(4'hF, 4'h0, e);
    n_vec++; if (sel !== 4'hF) begin n_err++; $display("FAIL hs_run_sel: got %h want f", sel); end
    cfg_valid = 1'b1;
    cfg_mode  = 2'd0;
    step();
    cfg_valid = 1'b0;
    n_vec++; if (active !== 1'b0 || sel !== 4'h0 || cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL hs_off: got active %b sel %h ready %b want 0 0 1", active, sel, cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_mode  = 2'd3;
    step();
    cfg_valid = 1'b0;
    step();
    n_vec++; if (active !== 1'b0 || sel !== 4'h0) begin
      n_err++; $display("FAIL hs_rsvd: got active %b sel %h want 0 0", active, sel);
    end
  endtask

  task automatic test_sat_reset();
    logic [DW-1:0] e;
    do_cfg(2'd2, 32'h0);
    force dut.delay_cnt_q = 16'hFFFE;
    #1;
    release dut.delay_cnt_q;
    exp_dcnt = 16'hFFFE;
    for (int k = 0; k < 4; k++) drive_cycle(4'hF, 4'h0, e);
    n_vec++; if (delay_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_dcnt: got %h want ffff", delay_cnt); end
    n_vec++; if (sel !== 4'hF) begin n_err++; $display("FAIL sat_sel: got %h want f", sel); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (sel !== 4'h0) begin n_err++; $display("FAIL midrst_sel: got %h want 0", sel); end
    n_vec++; if (delay_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_dcnt: got %h want 0", delay_cnt); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", cfg_ready); end
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL midrst_active: got %b want 0", active); end
  endtask

  initial begin
    test_reset();
    test_always();
    test_random();
    test_zero_seed();
    test_handshake();
    test_sat_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
